// File: rtl/int_res_mem_arbiter_pkg.sv
// Shared types for the intermediate-results memory arbiter: requester ids,
// address/data/format types and the memory-side request structs.
package int_res_mem_arbiter_pkg;

   localparam int N_INT_RES_REQ  = 4;
   localparam int INT_RES_ADDR_W = 10;
   localparam int COMP_FX_W      = 16;

   typedef logic [$clog2(N_INT_RES_REQ)-1:0] IntResReqId_t;

   typedef enum logic [1:0] {
      REQ_CTRL      = 2'd0,
      REQ_MAC       = 2'd1,
      REQ_SOFTMAX   = 2'd2,
      REQ_LAYERNORM = 2'd3
   } IntResRequester_e;

   typedef logic [INT_RES_ADDR_W-1:0] IntResAddr_t;
   typedef logic [COMP_FX_W-1:0]      CompFx_t;

   typedef enum logic {
      SINGLE_WIDTH = 1'b0,
      DOUBLE_WIDTH = 1'b1
   } DataWidth_e;

   typedef enum logic [1:0] {
      INT_RES_SW_FX_5_X = 2'd0,
      INT_RES_SW_FX_6_X = 2'd1,
      INT_RES_DW_FX     = 2'd2
   } FxFormatIntRes_t;

   // format on the read port is the cast applied to the data returning this cycle
   typedef struct packed {
      logic            en;
      IntResAddr_t     addr;
      logic            data_width;
      FxFormatIntRes_t format;
   } MemRdReq_t;

   typedef struct packed {
      logic            chip_en;
      logic            en;
      IntResAddr_t     addr;
      CompFx_t         data;
      logic            data_width;
      FxFormatIntRes_t format;
   } MemWrReq_t;

endpackage

// File: rtl/int_res_mem_arbiter_rr.sv
// Round-robin arbiter with burst lock and starvation cap. Offers a candidate
// combinationally; the parent may veto it with stall, which freezes all state.
module rr_lock_arbiter #(
   parameter int N         = 4,
   parameter int MAX_BURST = 16,
   localparam int IW       = (N > 1) ? $clog2(N) : 1,
   localparam int CW       = $clog2(MAX_BURST + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  lock,
   input  logic          stall,
   output logic          cand_vld,
   output logic [IW-1:0] cand_id,
   output logic [N-1:0]  gnt
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] holder_q;
   logic          held_q;
   logic [CW-1:0] burst_q;

   logic          rr_vld;
   logic [IW-1:0] rr_id;
   logic [IW-1:0] idx;
   logic [N-1:0]  holder_mask;
   logic          others;
   logic          starve;
   logic          lock_hit;
   logic          take;

   always_comb begin
      rr_vld = 1'b0;
      rr_id  = '0;
      idx    = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr_q) + k) % N);
         if (!rr_vld && req[idx]) begin
            rr_vld = 1'b1;
            rr_id  = idx;
         end
      end
   end

   // the cap only bites when someone else is actually waiting
   assign holder_mask = N'(1) << holder_q;
   assign others      = |(req & ~holder_mask);
   assign starve      = (burst_q == CW'(MAX_BURST)) && others;
   assign lock_hit    = held_q && req[holder_q] && lock[holder_q] && !starve;

   assign cand_vld = !rst && (lock_hit || rr_vld);
   assign cand_id  = lock_hit ? holder_q : rr_id;
   assign take     = cand_vld && !stall;
   assign gnt      = take ? (N'(1) << cand_id) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q    <= '0;
         holder_q <= '0;
         held_q   <= 1'b0;
         burst_q  <= '0;
      end else if (take) begin
         holder_q <= cand_id;
         held_q   <= lock[cand_id];
         if (!lock_hit)
            ptr_q <= (cand_id == IW'(N - 1)) ? '0 : cand_id + 1'b1;
         if (!lock[cand_id])
            burst_q <= '0;
         else if (!lock_hit)
            burst_q <= CW'(1);
         else if (burst_q != CW'(MAX_BURST))
            burst_q <= burst_q + 1'b1;
      end
   end

endmodule

// File: rtl/int_res_mem_arbiter.sv
// Shares the int_res_mem read and write ports among N_REQ requesters, with
// one-cycle tagged read return and format/RAW hazard bubbles on the read port.
module int_res_mem_arbiter
   import int_res_mem_arbiter_pkg::*;
#(
   parameter int N_REQ     = N_INT_RES_REQ,
   parameter int MAX_BURST = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic            [N_REQ-1:0]       rd_req,
   input  logic            [N_REQ-1:0]       rd_lock,
   input  IntResAddr_t     [N_REQ-1:0]       rd_addr,
   input  logic            [N_REQ-1:0]       rd_width,
   input  FxFormatIntRes_t [N_REQ-1:0]       rd_format,
   output logic            [N_REQ-1:0]       rd_gnt,
   output logic            [N_REQ-1:0]       rd_rvalid,
   output CompFx_t                           rd_rdata,
   input  logic            [N_REQ-1:0]       wr_req,
   input  logic            [N_REQ-1:0]       wr_lock,
   input  IntResAddr_t     [N_REQ-1:0]       wr_addr,
   input  logic            [N_REQ-1:0]       wr_width,
   input  FxFormatIntRes_t [N_REQ-1:0]       wr_format,
   input  CompFx_t         [N_REQ-1:0]       wr_data,
   output logic            [N_REQ-1:0]       wr_gnt,
   output MemRdReq_t                         mem_read,
   input  CompFx_t                           mem_rdata,
   output MemWrReq_t                         mem_write
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic            rd_cand_vld, wr_cand_vld;
   logic [IW-1:0]   rd_cand, wr_cand;
   logic            fmt_hazard, raw_hazard, rd_stall;
   logic            rd_fire, wr_fire;
   logic [N_REQ-1:0] rvalid_q;
   FxFormatIntRes_t ret_format_q;

   rr_lock_arbiter #(.N(N_REQ), .MAX_BURST(MAX_BURST)) u_rd_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (rd_req),
      .lock     (rd_lock),
      .stall    (rd_stall),
      .cand_vld (rd_cand_vld),
      .cand_id  (rd_cand),
      .gnt      (rd_gnt)
   );

   rr_lock_arbiter #(.N(N_REQ), .MAX_BURST(MAX_BURST)) u_wr_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (wr_req),
      .lock     (wr_lock),
      .stall    (1'b0),
      .cand_vld (wr_cand_vld),
      .cand_id  (wr_cand),
      .gnt      (wr_gnt)
   );

   // A double read issued now would overlap a return still cast with a single format.
   assign fmt_hazard = rd_cand_vld && (rd_width[rd_cand] == DOUBLE_WIDTH) &&
                       (ret_format_q != INT_RES_DW_FX) && (|rvalid_q);
   // Same-address write wins; the read retries next cycle and sees the new data.
   assign raw_hazard = rd_cand_vld && wr_cand_vld && (rd_addr[rd_cand] == wr_addr[wr_cand]);
   assign rd_stall   = fmt_hazard || raw_hazard;

   assign rd_fire = |rd_gnt;
   assign wr_fire = |wr_gnt;

   always_comb begin
      mem_read        = '0;
      mem_read.format = ret_format_q;
      if (rd_fire) begin
         mem_read.en         = 1'b1;
         mem_read.addr       = rd_addr[rd_cand];
         mem_read.data_width = rd_width[rd_cand];
      end
   end

   always_comb begin
      mem_write         = '0;
      mem_write.chip_en = !rst;
      if (wr_fire) begin
         mem_write.en         = 1'b1;
         mem_write.addr       = wr_addr[wr_cand];
         mem_write.data       = wr_data[wr_cand];
         mem_write.data_width = wr_width[wr_cand];
         mem_write.format     = wr_format[wr_cand];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q     <= '0;
         ret_format_q <= INT_RES_DW_FX;
      end else begin
         rvalid_q <= rd_gnt;
         if (rd_fire)
            ret_format_q <= rd_format[rd_cand];
      end
   end

   assign rd_rvalid = rvalid_q;
   assign rd_rdata  = mem_rdata;

   a_rd_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rd_gnt));
   a_wr_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(wr_gnt));
   a_fmt_safe:  assert property (@(posedge clk) disable iff (rst)
      !(mem_read.en && (mem_read.data_width == DOUBLE_WIDTH) && (|rvalid_q) &&
        (ret_format_q != INT_RES_DW_FX)));

endmodule

// File: tb/tb_int_res_mem_arbiter.sv
// Bench for int_res_mem_arbiter: directed scenarios plus random traffic
// scored against a port-level arbitration model and a shadow memory.
module tb_int_res_mem_arbiter;
   import int_res_mem_arbiter_pkg::*;

   localparam int N    = 4;
   localparam int MAXB = 16;

   logic clk, rst;
   logic [N-1:0] rd_req, rd_lock, rd_width, rd_gnt, rd_rvalid;
   logic [N-1:0] wr_req, wr_lock, wr_width, wr_gnt;
   IntResAddr_t     [N-1:0] rd_addr, wr_addr;
   FxFormatIntRes_t [N-1:0] rd_format, wr_format;
   CompFx_t         [N-1:0] wr_data;
   CompFx_t   rd_rdata, env_rdq;
   MemRdReq_t mem_read;
   MemWrReq_t mem_write;

   int_res_mem_arbiter #(.N_REQ(N), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_lock(rd_lock), .rd_addr(rd_addr), .rd_width(rd_width),
      .rd_format(rd_format), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
      .wr_req(wr_req), .wr_lock(wr_lock), .wr_addr(wr_addr), .wr_width(wr_width),
      .wr_format(wr_format), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .mem_read(mem_read), .mem_rdata(env_rdq), .mem_write(mem_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory behind the arbiter: registered read, write at edge
   CompFx_t env_mem [64];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) env_mem[i] <= CompFx_t'(i * 37 + 5);
      end else begin
         if (mem_read.en)  env_rdq <= env_mem[mem_read.addr[5:0]];
         if (mem_write.en) env_mem[mem_write.addr[5:0]] <= mem_write.data;
      end
   end

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: index 0 = read port, 1 = write port
   int  m_ptr[2], m_hold[2], m_burst[2];
   bit  m_held[2];
   FxFormatIntRes_t m_fmt;
   bit  m_pend, rv_known;
   logic [N-1:0] m_rv;
   CompFx_t m_data;
   CompFx_t shadow [64];
   int  last_rw = -1, last_ww = -1;
   logic [N-1:0] obs_rd_gnt, obs_wr_gnt, obs_rv;
   CompFx_t obs_rdata;
   FxFormatIntRes_t obs_fmt;

   function automatic logic [N-1:0] onehot(input int w);
      logic [N-1:0] v;
      v = '0;
      if (w >= 0) v[w] = 1'b1;
      return v;
   endfunction

   function automatic int pick(input int p, input logic [N-1:0] req, input logic [N-1:0] lock,
                               output bit locked);
      bit others;
      locked = 1'b0;
      others = 1'b0;
      if (m_held[p] && m_hold[p] >= 0 && req[m_hold[p]] && lock[m_hold[p]]) begin
         for (int i = 0; i < N; i++) if (i != m_hold[p] && req[i]) others = 1'b1;
         if (!(m_burst[p] >= MAXB && others)) begin
            locked = 1'b1;
            return m_hold[p];
         end
      end
      for (int k = 0; k < N; k++) if (req[(m_ptr[p] + k) % N]) return (m_ptr[p] + k) % N;
      return -1;
   endfunction

   task automatic commit(input int p, input int w, input bit locked, input logic [N-1:0] lock);
      if (w < 0) return;
      if (!locked) m_ptr[p] = (w + 1) % N;
      if (!lock[w])     m_burst[p] = 0;
      else if (!locked) m_burst[p] = 1;
      else if (m_burst[p] < MAXB) m_burst[p]++;
      m_held[p] = lock[w];
      m_hold[p] = w;
   endtask

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         m_ptr[p] = 0; m_hold[p] = -1; m_burst[p] = 0; m_held[p] = 1'b0;
      end
      m_fmt = INT_RES_DW_FX; m_pend = 1'b0; m_rv = '0;
      for (int i = 0; i < 64; i++) shadow[i] = CompFx_t'(i * 37 + 5);
   endtask

   // evaluate one cycle with the current inputs, then advance to the next negedge
   task automatic step();
      int rw, ww;
      bit rl, wl;
      rw = -1; ww = -1; rl = 1'b0; wl = 1'b0;
      #1;
      if (!rst) begin
         ww = pick(1, wr_req, wr_lock, wl);
         rw = pick(0, rd_req, rd_lock, rl);
         if (rw >= 0)
            if ((rd_width[rw] == DOUBLE_WIDTH && m_fmt != INT_RES_DW_FX && m_pend) ||
                (ww >= 0 && rd_addr[rw] == wr_addr[ww])) rw = -1;
      end
      obs_rd_gnt = rd_gnt; obs_wr_gnt = wr_gnt; obs_rv = rd_rvalid;
      obs_rdata = rd_rdata; obs_fmt = mem_read.format;
      chk("rd_gnt", 32'(rd_gnt), 32'(onehot(rw)));
      chk("wr_gnt", 32'(wr_gnt), 32'(onehot(ww)));
      chk("mrd_en", 32'(mem_read.en), 32'(rw >= 0));
      chk("mrd_addr", 32'(mem_read.addr), (rw >= 0) ? 32'(rd_addr[rw]) : 32'd0);
      chk("mwr_en", 32'(mem_write.en), 32'(ww >= 0));
      chk("mwr_addr", 32'(mem_write.addr), (ww >= 0) ? 32'(wr_addr[ww]) : 32'd0);
      chk("mwr_data", 32'(mem_write.data), (ww >= 0) ? 32'(wr_data[ww]) : 32'd0);
      chk("chip_en", 32'(mem_write.chip_en), 32'(!rst));
      if (rv_known) begin
         chk("mrd_fmt", 32'(mem_read.format), 32'(m_fmt));
         chk("rvalid", 32'(rd_rvalid), 32'(m_rv));
         if (m_rv != '0) chk("rdata", 32'(rd_rdata), 32'(m_data));
      end
      if (rst) begin
         model_reset();
         rv_known = 1'b1;
      end else begin
         m_rv = onehot(rw);
         m_pend = (rw >= 0);
         if (rw >= 0) begin
            m_data = shadow[rd_addr[rw][5:0]];
            m_fmt  = rd_format[rw];
         end
         if (ww >= 0) shadow[wr_addr[ww][5:0]] = wr_data[ww];
         commit(0, rw, rl, rd_lock);
         commit(1, ww, wl, wr_lock);
      end
      last_rw = rw; last_ww = ww;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear();
      rd_req = '0; rd_lock = '0; rd_width = '0; wr_req = '0; wr_lock = '0; wr_width = '0;
      for (int i = 0; i < N; i++) begin
         rd_addr[i] = '0; wr_addr[i] = '0; wr_data[i] = '0;
         rd_format[i] = INT_RES_SW_FX_5_X; wr_format[i] = INT_RES_SW_FX_5_X;
      end
   endtask

   task automatic rand_next();
      for (int i = 0; i < N; i++) begin
         if (!rd_req[i] || last_rw == i) begin
            rd_req[i]    = ($urandom_range(0, 99) < 55);
            rd_lock[i]   = ($urandom_range(0, 3) == 0);
            rd_addr[i]   = IntResAddr_t'($urandom_range(0, 7));
            rd_width[i]  = 1'($urandom_range(0, 1));
            rd_format[i] = rd_width[i] ? INT_RES_DW_FX :
                           ($urandom_range(0, 1) ? INT_RES_SW_FX_5_X : INT_RES_SW_FX_6_X);
         end else if ($urandom_range(0, 19) == 0) rd_req[i] = 1'b0;
         if (!wr_req[i] || last_ww == i) begin
            wr_req[i]    = ($urandom_range(0, 99) < 45);
            wr_lock[i]   = ($urandom_range(0, 3) == 0);
            wr_addr[i]   = IntResAddr_t'($urandom_range(0, 7));
            wr_width[i]  = 1'($urandom_range(0, 1));
            wr_format[i] = wr_width[i] ? INT_RES_DW_FX : INT_RES_SW_FX_6_X;
            wr_data[i]   = CompFx_t'($urandom);
         end else if ($urandom_range(0, 19) == 0) wr_req[i] = 1'b0;
      end
   endtask

   int  n1;
   bit  seen2;

   initial begin
      rv_known = 1'b0;
      clear();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;

      // all four reading, no lock: plain rotation
      rd_req = '1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("t1_rot", 32'(obs_rd_gnt), 32'(1 << (k % 4)));
      end

      // MAC holds a locked burst while SOFTMAX waits
      clear();
      rd_req[REQ_MAC] = 1'b1; rd_lock[REQ_MAC] = 1'b1; rd_req[REQ_SOFTMAX] = 1'b1;
      n1 = 0; seen2 = 1'b0;
      for (int k = 0; k < 40 && !seen2; k++) begin
         step();
         if (obs_rd_gnt == 4'b0010) n1++;
         else if (obs_rd_gnt == 4'b0100) seen2 = 1'b1;
      end
      chk("t2_burst", 32'(n1), 32'(MAXB));
      chk("t2_seen2", 32'(seen2), 32'd1);
      clear();
      rd_req = 4'b1011;
      step();
      chk("t2_ptr3", 32'(obs_rd_gnt), 32'b1000);

      // single 5_X read followed by a double read: one bubble
      clear();
      rd_req[0] = 1'b1; rd_addr[0] = IntResAddr_t'(5);
      step();
      chk("t3_single", 32'(obs_rd_gnt), 32'b0001);
      clear();
      rd_req[1] = 1'b1; rd_addr[1] = IntResAddr_t'(6);
      rd_width[1] = DOUBLE_WIDTH; rd_format[1] = INT_RES_DW_FX;
      step();
      chk("t3_bubble", 32'(obs_rd_gnt), 32'd0);
      chk("t3_fmt5x", 32'(obs_fmt), 32'(INT_RES_SW_FX_5_X));
      step();
      chk("t3_double", 32'(obs_rd_gnt), 32'b0010);
      clear();
      step();
      chk("t3_fmtdw", 32'(obs_fmt), 32'(INT_RES_DW_FX));

      // read and write to the same address in the same cycle
      clear();
      wr_req[2] = 1'b1; wr_addr[2] = IntResAddr_t'(40); wr_data[2] = 16'h1234;
      wr_width[2] = DOUBLE_WIDTH; wr_format[2] = INT_RES_DW_FX;
      rd_req[3] = 1'b1; rd_addr[3] = IntResAddr_t'(40);
      rd_width[3] = DOUBLE_WIDTH; rd_format[3] = INT_RES_DW_FX;
      step();
      chk("t4_rdstall", 32'(obs_rd_gnt), 32'd0);
      chk("t4_wrgo", 32'(obs_wr_gnt), 32'b0100);
      wr_req = '0;
      step();
      chk("t4_rdgo", 32'(obs_rd_gnt), 32'b1000);
      clear();
      step();
      chk("t4_rv", 32'(obs_rv), 32'b1000);
      chk("t4_rdata", 32'(obs_rdata), 32'h1234);

      // reset while a read is returning
      clear();
      rd_req[2] = 1'b1;
      step();
      chk("t5_pre", 32'(obs_rd_gnt), 32'b0100);
      rst = 1'b1;
      step();
      rst = 1'b0;
      rd_req = '1;
      step();
      chk("t5_rv0", 32'(obs_rv), 32'd0);
      chk("t5_first", 32'(obs_rd_gnt), 32'b0001);

      // independent read and write, different addresses
      clear();
      rd_req[1] = 1'b1; rd_addr[1] = IntResAddr_t'(3);
      wr_req[2] = 1'b1; wr_addr[2] = IntResAddr_t'(9); wr_data[2] = 16'hbeef;
      step();
      chk("t6_rd", 32'(obs_rd_gnt), 32'b0010);
      chk("t6_wr", 32'(obs_wr_gnt), 32'b0100);
      clear();
      step();

      // random traffic with occasional reset
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 599) == 0);
         rand_next();
         step();
      end
      rst = 1'b0;
      clear();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
